// File: rtl/color_pkg.sv
// Shared types and defaults for the per-channel colour faders.
package color_pkg;

   localparam int unsigned CHAN_W = 8;

   localparam logic [CHAN_W-1:0] STEP_DEFAULT        = 8'd8;
   localparam logic [CHAN_W-1:0] FLASH_VALUE_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      StIdle,
      StRamp,
      StFlash
   } fader_state_e;

endpackage

// File: rtl/vsync_tick.sv
// One-cycle frame tick on each falling edge of the active-low vertical sync.
module vsync_tick (
   input  logic clk_i,
   input  logic reset_i,
   input  logic vs_i,
   output logic tick_o
);

   logic vs_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vs_q <= 1'b1;
      end else begin
         vs_q <= vs_i;
      end
   end

   assign tick_o = vs_q & ~vs_i;

endmodule

// File: rtl/color_channel_fader.sv
// Steps one colour channel toward its software target once per frame, with a
// timed full-value flash override.
module color_channel_fader
   import color_pkg::*;
#(
   parameter logic [CHAN_W-1:0] STEP         = STEP_DEFAULT,
   parameter logic [CHAN_W-1:0] FLASH_VALUE  = FLASH_VALUE_DEFAULT,
   parameter int unsigned       FLASH_FRAMES = 4,
   parameter logic [CHAN_W-1:0] RESET_VALUE  = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CHAN_W-1:0] target_in,
   input  logic              vs,
   input  logic              flash_req,
   output logic [CHAN_W-1:0] chan_out,
   output logic              settled,
   output logic              flash_active
);

   localparam logic [7:0] FlashLoad = 8'(FLASH_FRAMES - 1);

   logic              tick;
   logic [CHAN_W-1:0] target_q;
   fader_state_e      state_q, state_d;
   logic [CHAN_W-1:0] chan_q, chan_d;
   logic [7:0]        flash_cnt_q, flash_cnt_d;
   logic              flash_pend_q, flash_pend_d;
   logic              settled_q, flash_active_q;
   logic [CHAN_W:0]   diff;
   logic [CHAN_W-1:0] stepped;
   logic              flash_go;

   vsync_tick u_vsync_tick (
      .clk_i   (clk),
      .reset_i (reset),
      .vs_i    (vs),
      .tick_o  (tick)
   );

   // One step toward target_q; the 9-bit distance makes the final step snap
   // exactly onto the target instead of overshooting or wrapping.
   always_comb begin
      diff    = '0;
      stepped = chan_q;
      if (target_q > chan_q) begin
         diff    = {1'b0, target_q} - {1'b0, chan_q};
         stepped = (STEP == '0 || diff <= {1'b0, STEP}) ? target_q : chan_q + STEP;
      end else if (target_q < chan_q) begin
         diff    = {1'b0, chan_q} - {1'b0, target_q};
         stepped = (STEP == '0 || diff <= {1'b0, STEP}) ? target_q : chan_q - STEP;
      end
   end

   always_comb begin
      state_d      = state_q;
      chan_d       = chan_q;
      flash_cnt_d  = flash_cnt_q;
      flash_pend_d = flash_pend_q | flash_req;
      flash_go     = flash_pend_q | flash_req;
      if (tick) begin
         flash_pend_d = 1'b0;
         unique case (state_q)
            StIdle, StRamp: begin
               if (flash_go) begin
                  state_d     = StFlash;
                  chan_d      = FLASH_VALUE;
                  flash_cnt_d = FlashLoad;
               end else if (chan_q != target_q) begin
                  chan_d  = stepped;
                  state_d = (stepped == target_q) ? StIdle : StRamp;
               end else begin
                  state_d = StIdle;
               end
            end
            StFlash: begin
               if (flash_go) begin
                  flash_cnt_d = FlashLoad;
               end else if (flash_cnt_q == 8'd0) begin
                  // Leaving the flash takes the first step back toward the target.
                  chan_d  = stepped;
                  state_d = (stepped == target_q) ? StIdle : StRamp;
               end else begin
                  flash_cnt_d = flash_cnt_q - 8'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         target_q       <= '0;
         state_q        <= StIdle;
         chan_q         <= RESET_VALUE;
         flash_cnt_q    <= 8'd0;
         flash_pend_q   <= 1'b0;
         settled_q      <= (RESET_VALUE == '0);
         flash_active_q <= 1'b0;
      end else begin
         target_q       <= target_in;
         state_q        <= state_d;
         chan_q         <= chan_d;
         flash_cnt_q    <= flash_cnt_d;
         flash_pend_q   <= flash_pend_d;
         settled_q      <= (state_d == StIdle) && (chan_d == target_in);
         flash_active_q <= (state_d == StFlash);
      end
   end

   assign chan_out     = chan_q;
   assign settled      = settled_q;
   assign flash_active = flash_active_q;

endmodule
